// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and default width for the bit-serial ALU and its bench.
package alu_pkg;

  localparam int unsigned DefaultN = 8;

  typedef enum logic [2:0] {
    OpInc = 3'b000,
    OpAdd = 3'b001,
    OpSub = 3'b010,
    OpDec = 3'b011,
    OpAnd = 3'b100,
    OpOr  = 3'b101,
    OpXor = 3'b110,
    OpNot = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Carry-in for bit 0: the +1 of increment/subtract, or the initial borrow of decrement.
  function automatic logic init_carry(op_e op);
    return (op == OpInc) || (op == OpSub) || (op == OpDec);
  endfunction

endpackage

// File: rtl/bit_serial_alu_if.sv
// Operand/result handshake bundle between a requester and the bit-serial ALU.
interface bit_serial_alu_if #(
  parameter int unsigned N = alu_pkg::DefaultN
) ();
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   S;
  logic [N-1:0] F;
  logic         Cout;
  logic         busy;
  logic         done;

  modport master (
    output start, A, B, S,
    input  F, Cout, busy, done
  );

  modport slave (
    input  start, A, B, S,
    output F, Cout, busy, done
  );
endinterface

// File: rtl/onebit.sv
// Single-bit ALU slice; the carry input doubles as a borrow for decrement.
module onebit
  import alu_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  input  op_e  op_i,
  output logic f_o,
  output logic cout_o
);

  logic nb;
  assign nb = ~b_i;

  always_comb begin
    f_o    = 1'b0;
    cout_o = 1'b0;
    unique case (op_i)
      OpInc: begin
        f_o    = a_i ^ cin_i;
        cout_o = a_i & cin_i;
      end
      OpAdd: begin
        f_o    = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
      end
      OpSub: begin
        f_o    = a_i ^ nb ^ cin_i;
        cout_o = (a_i & nb) | (cin_i & (a_i ^ nb));
      end
      OpDec: begin
        f_o    = a_i ^ cin_i;
        cout_o = ~a_i & cin_i;
      end
      OpAnd: f_o = a_i & b_i;
      OpOr:  f_o = a_i | b_i;
      OpXor: f_o = a_i ^ b_i;
      OpNot: f_o = ~a_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu.sv
// N-bit ALU evaluated LSB first through one onebit slice, one bit per clock.
module bit_serial_alu
  import alu_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic            clk,
  input  logic            rst,
  bit_serial_alu_if.slave bus
);

  localparam int unsigned CntW = $clog2(N + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  op_e             op_q, op_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    res_q, res_d;
  logic [N-1:0]    f_q, f_d;
  logic            cout_q, cout_d;

  logic slice_f;
  logic slice_cout;

  onebit u_onebit (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .op_i   (op_q),
    .f_o    (slice_f),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    res_d   = res_q;
    f_d     = f_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = op_e'(bus.S);
          carry_d = init_carry(op_e'(bus.S));
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d   = {slice_f, res_q[N-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // Logic ops never propagate a carry, whatever the slice reports.
        carry_d = op_q[2] ? 1'b0 : slice_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          f_d     = res_d;
          cout_d  = carry_d;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OpInc;
      carry_q <= 1'b0;
      res_q   <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.F    = f_q;
  assign bus.Cout = cout_q;
  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);

endmodule

// File: tb/tb_bit_serial_alu.sv
// Scoreboard bench for bit_serial_alu: expected results queued at issue, checked on done.
module tb_bit_serial_alu;
  import alu_pkg::*;

  localparam int unsigned N = DefaultN;

  typedef struct {
    logic [N-1:0] f;
    logic         c;
    int unsigned  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  exp_t sb[$];
  logic [N-1:0] last_f = '0;
  logic         last_c = 1'b0;

  bit_serial_alu_if #(.N(N)) bus ();

  bit_serial_alu #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic [2:0] s);
    logic [N:0] r;
    case (s)
      3'd0:    r = {1'b0, a} + (N+1)'(1);
      3'd1:    r = {1'b0, a} + {1'b0, b};
      3'd2:    r = {(a >= b), a - b};
      3'd3:    r = {(a == '0), a - N'(1)};
      3'd4:    r = {1'b0, a & b};
      3'd5:    r = {1'b0, a | b};
      3'd6:    r = {1'b0, a ^ b};
      default: r = {1'b0, ~a};
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_f = '0;
        last_c = 1'b0;
      end else begin
        if (bus.busy) begin
          chk("F_hold_run", 32'(bus.F), 32'(last_f));
          chk("Cout_hold_run", 32'(bus.Cout), 32'(last_c));
        end
        if (bus.done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(bus.done), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("F", 32'(bus.F), 32'(e.f));
            chk("Cout", 32'(bus.Cout), 32'(e.c));
            chk("done_cycle", cyc, e.cyc);
            last_f = e.f;
            last_c = e.c;
          end
        end
      end
    end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((bus.busy || bus.done) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      chk("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Issue one op; optionally pulse a bogus start mid-run, which must be ignored.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] s,
                        input logic [N-1:0] ef, input logic ec, input bit glitch);
    exp_t e;
    wait_idle();
    bus.A = a;
    bus.B = b;
    bus.S = s;
    bus.start = 1'b1;
    e.f = ef;
    e.c = ec;
    e.cyc = cyc + 1 + N;
    sb.push_back(e);
    step();
    bus.start = 1'b0;
    bus.A = N'($urandom);
    bus.B = N'($urandom);
    bus.S = 3'($urandom);
    if (glitch) begin
      step();
      step();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    wait_drain();
  endtask

  task automatic run_rand(input bit glitch);
    logic [N-1:0] a, b;
    logic [2:0]   s;
    logic [N:0]   r;
    a = N'($urandom);
    b = N'($urandom);
    s = 3'($urandom);
    if ($urandom_range(0, 7) == 0) a = '0;
    if ($urandom_range(0, 7) == 0) a = '1;
    r = model(a, b, s);
    run_op(a, b, s, r[N-1:0], r[N], glitch);
  endtask

  initial begin
    exp_t e;
    logic [N:0] r;
    int unsigned t0;
    fork
      monitor();
    join_none
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.S = '0;
    step();
    step();
    chk("rst_F", 32'(bus.F), 32'd0);
    chk("rst_Cout", 32'(bus.Cout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    step();

    run_op(8'h3C, 8'h05, 3'b001, 8'h41, 1'b0, 1'b0);
    run_op(8'h06, 8'h05, 3'b010, 8'h01, 1'b1, 1'b1);
    run_op(8'h05, 8'h06, 3'b010, 8'hFF, 1'b0, 1'b0);
    run_op(8'hFF, 8'h00, 3'b000, 8'h00, 1'b1, 1'b1);
    run_op(8'h00, 8'h33, 3'b011, 8'hFF, 1'b1, 1'b0);
    run_op(8'hA5, 8'h0F, 3'b110, 8'hAA, 1'b0, 1'b1);
    run_op(8'hA5, 8'hFF, 3'b111, 8'h5A, 1'b0, 1'b0);

    // Abort in the fourth RUN cycle: no done, F/Cout forced to zero.
    wait_idle();
    bus.A = 8'h3C;
    bus.B = 8'h05;
    bus.S = 3'b001;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_F", 32'(bus.F), 32'd0);
    chk("abort_Cout", 32'(bus.Cout), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < N + 4; i++) step();
    run_op(8'h3C, 8'h05, 3'b001, 8'h41, 1'b0, 1'b0);

    // Start held high: ops accepted every N+2 cycles.
    wait_idle();
    bus.A = 8'h81;
    bus.B = 8'h7F;
    bus.S = 3'b001;
    bus.start = 1'b1;
    r = model(8'h81, 8'h7F, 3'b001);
    t0 = cyc;
    for (int j = 0; j < 3; j++) begin
      e.f = r[N-1:0];
      e.c = r[N];
      e.cyc = t0 + 1 + N + j * (N + 2);
      sb.push_back(e);
    end
    while (cyc < t0 + 1 + 2 * (N + 2)) step();
    bus.start = 1'b0;
    wait_drain();

    for (int i = 0; i < 40; i++) run_rand(1'($urandom_range(0, 1)));

    wait_idle();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
